// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART-to-LED receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clock cycles per 16x oversample tick, truncated.
  function automatic int baud_div(input int clk, input int baud);
    return clk / (baud * 16);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer: state follows the input once it has been stable.
// Latency: 2 sync cycles + DEBOUNCE_CYC + 1 cycles from a stable input edge.
// Backpressure: none; free-running.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  output logic btn_state
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= CW'(DEBOUNCE_CYC);
      state_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_async};
      // Any return to the accepted level restarts the stability window.
      if (sync_q[1] == state_q) begin
        cnt_q <= CW'(DEBOUNCE_CYC);
      end else if (cnt_q == '0) begin
        state_q <= sync_q[1];
        cnt_q   <= CW'(DEBOUNCE_CYC);
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign btn_state = state_q;

endmodule

// File: rtl/uart_led_param.sv
// UART receiver (16x oversampling) that latches error-free frames onto LEDs, button rotates view.
// Latency: display, rx_valid and flags update 1 cycle after the stop-bit sample tick.
// Backpressure: none; frames arriving are always consumed.
module uart_led_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic                 clk_pin,
  input  logic                 rst_pin,
  input  logic                 btn_pin,
  input  logic                 rxd_pin,
  output logic [DATA_BITS-1:0] led_pins,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int DW   = $clog2(DIV);
  localparam int HALF = DATA_BITS / 2;

  logic [DW-1:0]        div_q;
  logic                 tick;
  logic [1:0]           rxd_sync_q;
  logic                 rxd_s;
  logic                 btn_state;

  rx_state_t            state_q, state_d;
  logic [3:0]           sub_q, sub_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_mis_q, par_mis_d;
  logic [DATA_BITS-1:0] disp_q, disp_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 exp_par;
  logic [DATA_BITS-1:0] rot_w;

  assign tick  = (div_q == DW'(DIV - 1));
  assign rxd_s = rxd_sync_q[1];

  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      div_q      <= '0;
      rxd_sync_q <= 2'b11;
    end else begin
      div_q      <= tick ? '0 : div_q + 1'b1;
      rxd_sync_q <= {rxd_sync_q[0], rxd_pin};
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk       (clk_pin),
    .rst       (rst_pin),
    .btn_async (btn_pin),
    .btn_state (btn_state)
  );

  assign exp_par = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;

  always_ff @(posedge clk_pin) begin
    if (rst_pin) begin
      state_q   <= ST_IDLE;
      sub_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_mis_q <= 1'b0;
      disp_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_mis_q <= par_mis_d;
      disp_q    <= disp_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_mis_d = par_mis_q;
    disp_d    = disp_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_d = ST_START;
            sub_d   = '0;
          end
        end
        ST_START: begin
          if (sub_q == 4'd7) begin
            sub_d = '0;
            if (!rxd_s) begin
              state_d   = ST_DATA;
              bit_d     = '0;
              par_mis_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (sub_q == 4'd15) begin
            sub_d   = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == 4'(DATA_BITS - 1)) begin
              state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
        ST_PAR: begin
          if (sub_q == 4'd15) begin
            sub_d     = '0;
            par_mis_d = (rxd_s != exp_par);
            state_d   = ST_STOP;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (sub_q == 4'd15) begin
            sub_d = '0;
            if (rxd_s && !par_mis_q) begin
              disp_d  = shift_q;
              valid_d = 1'b1;
              ferr_d  = 1'b0;
              perr_d  = 1'b0;
              state_d = ST_IDLE;
            end else if (rxd_s) begin
              perr_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              perr_d  = perr_q | par_mis_q;
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
        ST_WAIT_IDLE: begin
          // A break keeps restarting the 16-tick run of idle ones.
          if (!rxd_s) begin
            sub_d = '0;
          end else if (sub_q == 4'd15) begin
            state_d = ST_IDLE;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rot_w      = (disp_q << HALF) | (disp_q >> (DATA_BITS - HALF));
  assign led_pins   = btn_state ? rot_w : disp_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_uart_led_param.sv
// Randomised scoreboard bench: DUT0 without parity, DUT1 with even parity, driven concurrently.
module tb_uart_led_param;

  localparam int BIT = 864;

  logic clk;
  logic rst0, rst1, btn0, btn1, rxd0, rxd1;
  logic [7:0] led0, led1;
  logic rx_valid0, rx_valid1, ferr0, ferr1, perr0, perr1;

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_disp[2];
  logic       exp_ferr[2];
  logic       exp_perr[2];
  logic       exp_btn[2];
  logic [7:0] e0, e1;

  uart_led_param #(.DEBOUNCE_CYC(16)) dut0 (
    .clk_pin(clk), .rst_pin(rst0), .btn_pin(btn0), .rxd_pin(rxd0),
    .led_pins(led0), .rx_valid(rx_valid0), .frame_err(ferr0), .parity_err(perr0)
  );

  uart_led_param #(.PARITY(1), .DEBOUNCE_CYC(16)) dut1 (
    .clk_pin(clk), .rst_pin(rst1), .btn_pin(btn1), .rxd_pin(rxd1),
    .led_pins(led1), .rx_valid(rx_valid1), .frame_err(ferr1), .parity_err(perr1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] shown(input logic [7:0] w, input logic b);
    return b ? {w[3:0], w[7:4]} : w;
  endfunction

  task automatic drive(input int w, input logic b, input int cyc);
    if (w == 0) rxd0 = b; else rxd1 = b;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input int w, input string tag);
    if (w == 0) begin
      chk({tag, " led0"}, led0, shown(exp_disp[0], exp_btn[0]));
      chk({tag, " frame_err0"}, ferr0, exp_ferr[0]);
      chk({tag, " parity_err0"}, perr0, exp_perr[0]);
      chk({tag, " pending0"}, q0.size(), 0);
    end else begin
      chk({tag, " led1"}, led1, shown(exp_disp[1], exp_btn[1]));
      chk({tag, " frame_err1"}, ferr1, exp_ferr[1]);
      chk({tag, " parity_err1"}, perr1, exp_perr[1]);
      chk({tag, " pending1"}, q1.size(), 0);
    end
  endtask

  // One frame; par_good selects a correct or deliberately wrong parity bit on DUT1.
  task automatic send(input int w, input logic [7:0] d, input logic par_good,
                      input logic stop_b, input int extra_low, input string tag);
    logic pbit;
    logic par_ok;
    pbit   = (($countones(d) % 2) == 1) ^ !par_good;
    par_ok = (w == 0) || ((($countones(d) + int'(pbit)) % 2) == 0);
    if (stop_b && par_ok) begin
      if (w == 0) q0.push_back(d); else q1.push_back(d);
    end
    drive(w, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(w, d[i], BIT);
    if (w == 1) drive(w, pbit, BIT);
    drive(w, stop_b, BIT * (1 + extra_low));
    drive(w, 1'b1, 2 * BIT);
    if (stop_b && par_ok) begin
      exp_disp[w] = d;
      exp_ferr[w] = 1'b0;
      exp_perr[w] = 1'b0;
    end else if (stop_b) begin
      exp_perr[w] = 1'b1;
    end else begin
      exp_ferr[w] = 1'b1;
      if (!par_ok) exp_perr[w] = 1'b1;
    end
    @(negedge clk);
    check_state(w, tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rx_valid0) begin
      chk("dut0 rx_valid expected", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("dut0 rx word", led0, shown(e0, exp_btn[0]));
        chk("dut0 flags on rx", {ferr0, perr0}, 0);
      end
    end
    if (rx_valid1) begin
      chk("dut1 rx_valid expected", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("dut1 rx word", led1, shown(e1, exp_btn[1]));
        chk("dut1 flags on rx", {ferr1, perr1}, 0);
      end
    end
  end

  initial begin
    logic bad;
    logic bad1;
    logic [7:0] rd;
    clk = 0;
    rst0 = 1; rst1 = 1; rxd0 = 1; rxd1 = 1; btn0 = 0; btn1 = 0;
    for (int i = 0; i < 2; i++) begin
      exp_disp[i] = 0; exp_ferr[i] = 0; exp_perr[i] = 0; exp_btn[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst0 = 0; rst1 = 0;
    @(negedge clk);
    chk("reset led0", led0, 0);
    chk("reset rx_valid0", rx_valid0, 0);
    chk("reset flags0", {ferr0, perr0}, 0);
    chk("reset led1", led1, 0);
    chk("reset rx_valid1", rx_valid1, 0);
    chk("reset flags1", {ferr1, perr1}, 0);
    @(posedge clk);
    #1;

    fork
      begin
        bad = 0;
        repeat (20 * BIT) begin
          @(negedge clk);
          if (led0 !== 8'h00 || ferr0 !== 1'b0 || perr0 !== 1'b0 || rx_valid0 !== 1'b0) bad = 1;
        end
        chk("dut0 idle line stable", bad, 0);
        @(posedge clk);
        #1;
        send(0, 8'hA5, 1'b1, 1'b1, 0, "frame A5");

        btn0 = 1;
        repeat (18) @(posedge clk);
        @(negedge clk);
        chk("dut0 button before debounce", led0, 8'hA5);
        @(negedge clk);
        chk("dut0 button accepted", led0, 8'h5A);
        exp_btn[0] = 1;
        @(posedge clk);
        #1;

        drive(0, 1'b0, 300);
        drive(0, 1'b1, 2 * BIT);
        @(negedge clk);
        check_state(0, "false start");
        @(posedge clk);
        #1;
        send(0, 8'h3C, 1'b1, 1'b1, 0, "frame 3C");

        btn0 = 0;
        repeat (30) @(posedge clk);
        #1;
        exp_btn[0] = 0;
        chk("dut0 button released", led0, 8'h3C);

        send(0, 8'h81, 1'b1, 1'b0, 2, "frame 81 bad stop");
        send(0, 8'h42, 1'b1, 1'b1, 0, "frame 42");
        rd = 8'($urandom_range(0, 255));
        send(0, rd, 1'b1, 1'($urandom_range(0, 3) != 0), 0, "dut0 random");
      end
      begin
        send(1, 8'h07, 1'b0, 1'b1, 0, "frame 07 bad parity");
        send(1, 8'h07, 1'b1, 1'b1, 0, "frame 07 good parity");

        drive(1, 1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(1, 1'b1, BIT);
        drive(1, 1'b1, 400);
        rst1 = 1;
        repeat (2) @(posedge clk);
        #1;
        rst1 = 0;
        exp_disp[1] = 0; exp_ferr[1] = 0; exp_perr[1] = 0; exp_btn[1] = 0;
        @(negedge clk);
        chk("dut1 mid-frame reset led", led1, 0);
        chk("dut1 mid-frame reset flags", {ferr1, perr1}, 0);
        @(posedge clk);
        #1;
        drive(1, 1'b1, 2 * BIT);
        @(negedge clk);
        check_state(1, "after reset");
        @(posedge clk);
        #1;
        send(1, 8'h11, 1'b1, 1'b1, 0, "frame 11");

        btn1 = 1;
        repeat (10) @(posedge clk);
        #1;
        btn1 = 0;
        bad1 = 0;
        repeat (60) begin
          @(negedge clk);
          if (led1 !== 8'h11) bad1 = 1;
        end
        chk("dut1 button glitch ignored", bad1, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 2; k++) begin
          send(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) != 0), 0, "dut1 random");
        end
      end
    join

    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
